// File: rtl/fv_arf_shadow.sv
// Architectural register file shadow with end-of-program checker; optional FV_ARF_SHADOW_ZERO_REG_EN hardwires reg 0 of every file to zero.
// Latency: shadow/commit_count update one cycle after the write/commit; check_valid at least QUIET_CYCLES+1 cycles after fetch_done.
// Backpressure: none; a passive observer that never stalls the DUT and accepts every write and commit in every cycle.
module fv_arf_shadow #(
    parameter int NUM_RF       = 1,
    parameter int NUM_REGS     = 32,
    parameter int NUM_WR       = 1,
    parameter int REG_W        = 32,
    parameter int MAX_COMMIT   = 1,
    parameter int QUIET_CYCLES = 8,
    parameter int CNT_W        = 16,
    localparam int ADDR_W      = $clog2(NUM_REGS)
) (
    input  logic                              clk,
    input  logic                              reset_,
    input  logic [NUM_RF*NUM_REGS*REG_W-1:0]  arf_regs,
    input  logic [NUM_RF*NUM_WR-1:0]          wr_en,
    input  logic [NUM_RF*NUM_WR*ADDR_W-1:0]   wr_rd,
    input  logic [NUM_RF*NUM_WR*REG_W-1:0]    wr_data,
    input  logic [MAX_COMMIT-1:0]             commit,
    input  logic                              fetch_done,
    output logic [NUM_RF*NUM_REGS*REG_W-1:0]  shadow_regs,
    output logic [CNT_W-1:0]                  commit_count,
    output logic [1:0]                        state,
    output logic                              check_valid,
    output logic                              mismatch,
    output logic [1:0]                        mismatch_rf,
    output logic [ADDR_W-1:0]                 mismatch_idx,
    output logic                              late_write
);

`ifdef FV_ARF_SHADOW_ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif

    localparam int QW    = $clog2(QUIET_CYCLES + 1);
    localparam int SUM_W = CNT_W + $clog2(MAX_COMMIT + 1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                            state_q, state_d;
    logic [QW-1:0]                     quiet_q, quiet_d;
    logic [NUM_RF*NUM_REGS*REG_W-1:0]  shadow_q, shadow_d;
    logic [CNT_W-1:0]                  count_q, count_d;
    logic                              mismatch_q, mismatch_d;
    logic [1:0]                        mm_rf_q, mm_rf_d;
    logic [ADDR_W-1:0]                 mm_idx_q, mm_idx_d;
    logic                              late_q, late_d;

    logic                              activity;
    logic                              diff_found;
    logic [1:0]                        diff_rf;
    logic [ADDR_W-1:0]                 diff_idx;
    logic [SUM_W-1:0]                  count_sum;
    logic [REG_W-1:0]                  exp_val;
    int                                idx;

    assign activity = (|wr_en) | (|commit);

    // Shadow rebuild: ports applied in ascending order so the highest-numbered port wins a collision.
    always_comb begin
        shadow_d = shadow_q;
        idx      = 0;
        for (int f = 0; f < NUM_RF; f++) begin
            for (int p = 0; p < NUM_WR; p++) begin
                idx = int'(wr_rd[(f*NUM_WR+p)*ADDR_W +: ADDR_W]);
                if (wr_en[f*NUM_WR+p] && (idx < NUM_REGS) && !(ZERO_REG && (idx == 0))) begin
                    shadow_d[(f*NUM_REGS+idx)*REG_W +: REG_W] = wr_data[(f*NUM_WR+p)*REG_W +: REG_W];
                end
            end
        end
    end

    // Commit counter: add this cycle's popcount and clamp at all-ones instead of wrapping.
    always_comb begin
        count_sum = SUM_W'(count_q);
        for (int i = 0; i < MAX_COMMIT; i++) begin
            count_sum = count_sum + SUM_W'(commit[i]);
        end
        if (count_sum > SUM_W'({CNT_W{1'b1}})) begin
            count_d = {CNT_W{1'b1}};
        end else begin
            count_d = count_sum[CNT_W-1:0];
        end
    end

    // Final-state compare: scan from the top down so the last hit recorded is the lowest (file, reg) pair.
    always_comb begin
        diff_found = 1'b0;
        diff_rf    = '0;
        diff_idx   = '0;
        exp_val    = '0;
        for (int f = NUM_RF-1; f >= 0; f--) begin
            for (int r = NUM_REGS-1; r >= 0; r--) begin
                exp_val = (ZERO_REG && (r == 0)) ? '0 : shadow_q[(f*NUM_REGS+r)*REG_W +: REG_W];
                if (arf_regs[(f*NUM_REGS+r)*REG_W +: REG_W] != exp_val) begin
                    diff_found = 1'b1;
                    diff_rf    = 2'(f);
                    diff_idx   = ADDR_W'(r);
                end
            end
        end
    end

    // FSM next state, quiet counter and sticky result flags.
    always_comb begin
        state_d     = state_q;
        quiet_d     = quiet_q;
        mismatch_d  = mismatch_q;
        mm_rf_d     = mm_rf_q;
        mm_idx_d    = mm_idx_q;
        late_d      = late_q;
        check_valid = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (fetch_done) begin
                    state_d = ST_DRAIN;
                    quiet_d = '0;
                end
            end
            ST_DRAIN: begin
                if (activity) begin
                    quiet_d = '0;
                end else if (quiet_q == QW'(QUIET_CYCLES-1)) begin
                    state_d = ST_CHECK;
                end else begin
                    quiet_d = quiet_q + 1'b1;
                end
            end
            ST_CHECK: begin
                check_valid = 1'b1;
                if (diff_found && !mismatch_q) begin
                    mismatch_d = 1'b1;
                    mm_rf_d    = diff_rf;
                    mm_idx_d   = diff_idx;
                end
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (activity) begin
                    late_d = 1'b1;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // State registers with synchronous active-low reset; reset overrides any same-cycle write.
    always_ff @(posedge clk) begin
        if (!reset_) begin
            state_q    <= ST_RUN;
            quiet_q    <= '0;
            shadow_q   <= '0;
            count_q    <= '0;
            mismatch_q <= 1'b0;
            mm_rf_q    <= '0;
            mm_idx_q   <= '0;
            late_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            quiet_q    <= quiet_d;
            shadow_q   <= shadow_d;
            count_q    <= count_d;
            mismatch_q <= mismatch_d;
            mm_rf_q    <= mm_rf_d;
            mm_idx_q   <= mm_idx_d;
            late_q     <= late_d;
        end
    end

    assign shadow_regs  = shadow_q;
    assign commit_count = count_q;
    assign state        = state_q;
    assign mismatch     = mismatch_q;
    assign mismatch_rf  = mm_rf_q;
    assign mismatch_idx = mm_idx_q;
    assign late_write   = late_q;

endmodule
